// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divider; without it DIV*/REM* complete in one step with result 0.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);

    // FAST carries the one-cycle special-case path without raising busy.
    typedef enum logic [1:0] {IDLE, BUSY, FAST, DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [CW-1:0]      counter;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opd;
    logic               neg_res;
`ifdef MDU_DIV_EN
    logic               neg_rem;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
`endif

    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               special;
    logic [WIDTH-1:0]   special_val;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     hi_step;
    logic [WIDTH-1:0]   lo_step;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   final_val;

    // Edge-0 decode: operand signedness, magnitudes and the short-circuit cases.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        special     = 1'b0;
        special_val = '0;
        a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg       = a_signed & operand_a[WIDTH-1];
        b_neg       = b_signed & operand_b[WIDTH-1];
        a_mag       = a_neg ? ('0 - operand_a) : operand_a;
        b_mag       = b_neg ? ('0 - operand_b) : operand_b;
`ifdef MDU_DIV_EN
        if (funct3[2]) begin
            if (operand_b == '0) begin
                special     = 1'b1;
                special_val = funct3[1] ? operand_a : '1;
            end else if (!funct3[0] && operand_a == {1'b1, {(WIDTH-1){1'b0}}} &&
                         operand_b == '1) begin
                special     = 1'b1;
                special_val = funct3[1] ? '0 : operand_a;
            end
        end
`else
        special = funct3[2];
`endif
    end

    // One iteration of the shared {acc_hi, acc_lo} datapath, plus sign fix-up of the final value.
    always_comb begin
        mul_sum = acc_lo[0] ? (acc_hi + {1'b0, opd}) : acc_hi;
        hi_step = {1'b0, mul_sum[WIDTH:1]};
        lo_step = {mul_sum[0], acc_lo[WIDTH-1:1]};
        prod      = {acc_hi[WIDTH-1:0], acc_lo};
        prod_s    = neg_res ? ('0 - prod) : prod;
        final_val = (op == 3'b000) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
`ifdef MDU_DIV_EN
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};
        quot_s    = neg_res ? ('0 - acc_lo) : acc_lo;
        rem_s     = neg_rem ? ('0 - acc_hi[WIDTH-1:0]) : acc_hi[WIDTH-1:0];
        if (op[2]) begin
            final_val = op[1] ? rem_s : quot_s;
            if (!div_diff[WIDTH]) begin
                hi_step = {1'b0, div_diff[WIDTH-1:0]};
                lo_step = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = {1'b0, div_shift[WIDTH-1:0]};
                lo_step = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            counter <= '0;
            op      <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opd     <= '0;
            neg_res <= 1'b0;
`ifdef MDU_DIV_EN
            neg_rem <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        op      <= funct3;
                        neg_res <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        neg_rem <= a_neg;
`endif
                        acc_hi  <= '0;
                        if (special) begin
                            acc_lo <= special_val;
                            state  <= FAST;
                        end else begin
                            state   <= BUSY;
                            busy    <= 1'b1;
                            counter <= CW'(WIDTH);
                            // Multiply walks the multiplier in acc_lo; divide shifts the dividend out of it.
                            if (funct3[2]) begin
                                acc_lo <= a_mag;
                                opd    <= b_mag;
                            end else begin
                                acc_lo <= b_mag;
                                opd    <= a_mag;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (counter != '0) begin
                        acc_hi  <= hi_step;
                        acc_lo  <= lo_step;
                        counter <= counter - CW'(1);
                    end else begin
                        result <= final_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                FAST: begin
                    result <= acc_lo;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed ops plus random ops against a behavioural model.
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mdu_iterative #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dv(input logic [31:0] v);
`ifdef MDU_DIV_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EN
        return f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return f[2] && (a === a) && (b === b);
`endif
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return is_special(f, a, b) ? 1 : 33;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0]        up;
        bit                 ovf;
        sa  = 64'($signed(a));
        sb  = 64'($signed(b));
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifndef MDU_DIV_EN
        if (f[2]) return 32'h0;
`endif
        case (f)
            3'b000: return a * b;
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin up = 64'(a) * 64'(b); return up[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive a request and record what the unit must answer with.
    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        exp_t e;
        start     = 1'b1;
        funct3    = f;
        operand_a = a;
        operand_b = b;
        e.res = res;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Clock edge 0, then wait (bounded) for done and compare against the scoreboard head.
    task automatic collect(input string tag, input bit poke);
        exp_t e;
        int   n;
        bit   got, busy_ok;
        @(posedge clk);
        #1 start = 1'b0;
        e = exp_q.pop_front();
        n = 0; got = 1'b0; busy_ok = 1'b1;
        while (n < 100 && !got) begin
            if (poke && n == 4) begin
                start     = 1'b1;
                funct3    = 3'b011;
                operand_a = $urandom;
                operand_b = $urandom;
            end
            if (poke && n == 5) start = 1'b0;
            @(posedge clk);
            #1 n++;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== (e.lat > 1)) busy_ok = 1'b0;
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, n, e.lat);
        check({tag, " result"}, result, e.res);
        check({tag, " busy"}, 32'(busy_ok && busy === 1'b0), 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
        drive(f, a, b, res, lat);
        collect(tag, 1'b0);
    endtask

    task automatic idle_check(input string tag, input logic [31:0] prev);
        @(posedge clk);
        #1;
        check({tag, " done drops"}, 32'(done), 32'd0);
        check({tag, " result holds"}, result, prev);
    endtask

    initial begin
        int seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("mul 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        idle_check("mul idle", 32'hFFFF_FFEB);
        run("mulh min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mulhu max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu -2*max", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

        run("div -20/3", 3'b100, 32'hFFFF_FFEC, 32'd3, dv(32'hFFFF_FFFA), lat_of(3'b100, 32'hFFFF_FFEC, 32'd3));
        run("rem -20%3", 3'b110, 32'hFFFF_FFEC, 32'd3, dv(32'hFFFF_FFFE), lat_of(3'b110, 32'hFFFF_FFEC, 32'd3));
        run("divu 100/7", 3'b101, 32'd100, 32'd7, dv(32'd14), lat_of(3'b101, 32'd100, 32'd7));
        run("div 5/0", 3'b100, 32'd5, 32'd0, dv(32'hFFFF_FFFF), 1);
        run("remu 5%0", 3'b111, 32'd5, 32'd0, dv(32'd5), 1);
        run("div min/-1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), 1);
        run("rem min%-1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Stray start during BUSY must not disturb the running op.
        drive(3'b000, 32'd1234, 32'd5678, 32'd7006652, 33);
        collect("start in busy", 1'b1);
        idle_check("after poke", 32'd7006652);

        // Back-to-back: new request held during the DONE cycle.
        run("b2b first", 3'b000, 32'd11, 32'd13, 32'd143, 33);
        drive(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 33);
        collect("b2b second", 1'b0);

        for (int i = 0; i < 10; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 3) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run($sformatf("rand%0d f=%0d", i, f), f, a, b, model(f, a, b), lat_of(f, a, b));
        end

        // Reset in the middle of a multiply aborts it with no done.
        start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done === 1'b1) seen++;
        end
        check("abort no done", seen, 32'd0);
        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
